imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//   Pipelined, parametrised RV32I/RV64I immediate generator between fetch and execute.
//   - Decodes the immediate, immediate format and an illegal-opcode flag from a 32-bit instruction.
//   - Passes the PC through alongside the decoded fields.
//   - Registered output stage with a 2-entry skid buffer and valid/ready on both sides.
//   - Saturating counter of illegal opcodes accepted.
// PARAMETERS
//   XLEN   32  datapath width; 32 or 64 (64 also decodes OP-IMM-32 0011011 / OP-32 0111011)
//   PC_W   32  width of the PC sideband
//   CNT_W  16  width of illegal-opcode counter
// PORTS
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   flush        in   1      synchronous pipeline flush
//   in_valid     in   1      input beat valid
//   in_ready     out  1      stage can accept a beat
//   in_instr     in   32     instruction word
//   in_pc        in   PC_W   instruction PC
//   out_valid    out  1      output beat valid
//   out_ready    in   1      downstream accepts the beat
//   out_imm      out  XLEN   sign/zero-extended immediate
//   out_pc       out  PC_W   PC of the output beat
//   out_fmt      out  3      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR uimm)
//   out_illegal  out  1      opcode not recognised
//   illegal_cnt  out  CNT_W  saturating count of illegal beats accepted
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     out_valid, out_imm, out_pc, out_fmt, out_illegal, illegal_cnt and both entry valid bits = 0.
//     in_ready = 1 while in reset and after release.
//   Decode, opcode in_instr[6:0]; immediate built then sign-extended to XLEN:
//     U (0110111, 0010111): {i[31:12],12'b0}, sign-extended from bit 31 (XLEN=64 too).
//     I (0000011, 0010011, 1100111; 0011011 if XLEN=64): i[31:20].
//     S (0100011): {i[31:25],i[11:7]}.
//     B (1100011): {i[31],i[7],i[30:25],i[11:8],1'b0}.
//     J (1101111): {i[31],i[19:12],i[20],i[30:21],1'b0}.
//     NONE, not illegal (0110011, 0001111, 1110011; 0111011 if XLEN=64): imm 0.
//     Any other opcode: imm 0, fmt NONE, illegal 1.
//   Pipeline:
//     Latency 1 cycle; throughput 1 beat/cycle while out_ready=1.
//     Accept = in_valid & in_ready & ~flush; the beat is decoded and written to the main (output) register.
//     out_valid=1 & out_ready=0 and a beat is accepted: it goes to the skid entry; in_ready=0 next cycle.
//     in_ready = ~skid_valid, registered; no combinational path from out_ready to in_ready.
//     Output handshake with skid full: skid moves to main, in_ready=1 next cycle.
//     Output handshake with skid empty and no accept: out_valid=0.
//     Output fields stay stable while out_valid=1 & out_ready=0.
//     Order is preserved; no beat is dropped or duplicated.
//   Flush: at the next edge both valid bits are cleared and out_valid=0.
//     A beat offered in the flush cycle is discarded.
//     illegal_cnt is unchanged by flush.
//   illegal_cnt: +1 per accepted beat with illegal=1; holds at all-ones.
//   Reset mid-operation: all state is cleared immediately, asynchronously.
// CONFIGURATION
//   IMM_GEN_CSR_EN defined: SYSTEM (1110011) with funct3 in {101,110,111} -> fmt Z,
//     imm = zero-extended i[19:15].
//   Not defined: every SYSTEM opcode -> fmt NONE, imm 0, illegal 0.
// TESTING
//   1. LUI 0x12345037 -> one cycle later out_imm=0x12345000, fmt=4.
//      XLEN=64: 0x800000B7 -> 0xFFFFFFFF80000000.
//   2. BEQ 0xFE000EE3, then JAL 0x0080006F back-to-back, out_ready=1
//      -> 0xFFFFFFFC fmt 3, then 0x00000008 fmt 5 on consecutive cycles, PCs preserved.
//   3. Stream PC 0x0,0x4,0x8 with out_ready=0 for 3 cycles -> in_ready=0 after second beat, 0x8 held;
//      release -> out_pc 0x0,0x4,0x8 in order, no loss.
//   4. Opcode 0x7F x5 with CNT_W=2 -> out_illegal=1, imm 0, fmt 0; illegal_cnt=3 (saturated).
//   5. Flush with main+skid full -> next cycle out_valid=0, in_ready=1.
//      rst_n low mid-stream -> all outputs 0 without a clock edge.
//   6. CSRRWI 0x3002D0F3 -> with IMM_GEN_CSR_EN imm=5 fmt=6; without, imm=0 fmt=0 illegal=0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate generator between fetch and execute.
//
// A 32-bit instruction is decoded into a sign/zero-extended immediate, its format code
// and an illegal-opcode flag. The result is registered together with the PC in a main
// output register, backed by one skid entry so that in_ready can be fully registered.
//
// Optional feature: define IMM_GEN_CSR_EN to decode the CSR immediate forms
// (CSRRWI/CSRRSI/CSRRCI) as format Z with a zero-extended rs1-field immediate.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   flush         synchronous flush, drops all buffered beats and the offered beat
//   in_valid      input beat valid
//   in_ready      stage can accept a beat (registered)
//   in_instr      instruction word
//   in_pc         instruction PC
//   out_valid     output beat valid
//   out_ready     downstream accepts the beat
//   out_imm       extended immediate
//   out_pc        PC of the output beat
//   out_fmt       0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
//   out_illegal   opcode not recognised
//   illegal_cnt   saturating count of illegal beats accepted
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [PC_W-1:0]  out_pc,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
`ifdef IMM_GEN_CSR_EN
  localparam logic [2:0] FmtZ    = 3'd6;
`endif

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpOp32   = 7'b0111011;

  localparam logic Rv64 = (XLEN == 64);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  always_comb begin
    dec_imm32   = '0;
    dec_fmt     = FmtNone;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      OpLui, OpAuipc: begin
        dec_imm32 = {in_instr[31:12], 12'b0};
        dec_fmt   = FmtU;
      end
      OpLoad, OpImm, OpJalr: begin
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_fmt   = FmtI;
      end
      OpImm32: begin
        if (Rv64) begin
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_fmt   = FmtI;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpStore: begin
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_fmt   = FmtS;
      end
      OpBranch: begin
        dec_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        dec_fmt   = FmtB;
      end
      OpJal: begin
        dec_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        dec_fmt   = FmtJ;
      end
      OpOp, OpFence: ;
      OpSystem: begin
`ifdef IMM_GEN_CSR_EN
        // funct3 1xx with non-zero low bits are the immediate CSR forms.
        if (in_instr[14] && (in_instr[13:12] != 2'b00)) begin
          dec_imm32 = {27'b0, in_instr[19:15]};
          dec_fmt   = FmtZ;
        end
`endif
      end
      OpOp32: dec_illegal = !Rv64;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Every format is built as a signed 32-bit value; Z has bit 31 clear so it zero-extends.
  assign dec_imm = XLEN'($signed(dec_imm32));

  // ---------------------------------------------------------------------------
  // Main register + skid entry
  // ---------------------------------------------------------------------------
  logic            main_valid, skid_valid;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic [PC_W-1:0] main_pc, skid_pc;
  logic [2:0]      main_fmt, skid_fmt;
  logic            main_illegal, skid_illegal;
  logic [CNT_W-1:0] cnt;

  logic accept;
  logic out_fire;

  // in_ready depends only on a flop, so out_ready never reaches it combinationally.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;
  assign out_fire = main_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid   <= 1'b0;
      main_imm     <= '0;
      main_pc      <= '0;
      main_fmt     <= FmtNone;
      main_illegal <= 1'b0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_pc      <= '0;
      skid_fmt     <= FmtNone;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_valid && !out_ready) begin
      // Output stalled: main holds, a new beat parks in the (empty) skid entry.
      if (accept) begin
        skid_valid   <= 1'b1;
        skid_imm     <= dec_imm;
        skid_pc      <= in_pc;
        skid_fmt     <= dec_fmt;
        skid_illegal <= dec_illegal;
      end
    end else if (skid_valid) begin
      // Output drained with skid full (no accept possible): skid moves up.
      main_valid   <= 1'b1;
      main_imm     <= skid_imm;
      main_pc      <= skid_pc;
      main_fmt     <= skid_fmt;
      main_illegal <= skid_illegal;
      skid_valid   <= 1'b0;
    end else begin
      // Main empty or draining, skid empty: load the new beat directly.
      main_valid <= accept;
      if (accept) begin
        main_imm     <= dec_imm;
        main_pc      <= in_pc;
        main_fmt     <= dec_fmt;
        main_illegal <= dec_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept && dec_illegal && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign out_valid   = main_valid;
  assign out_imm     = main_imm;
  assign out_pc      = main_pc;
  assign out_fmt     = main_fmt;
  assign out_illegal = main_illegal;
  assign illegal_cnt = cnt;

endmodule
